// File: rtl/ret_pop_sequencer_pkg.sv
// Shared types and constants for the return-context pop sequencer.
package proc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } pop_state_e;

    localparam logic [1:0] POP_WORDS_RTI = 2'd3;
    localparam logic [1:0] POP_WORDS_RET = 2'd2;
    localparam int         FLAG_W        = 3;

    function automatic logic [1:0] pop_words(input logic is_rti);
        return is_rti ? POP_WORDS_RTI : POP_WORDS_RET;
    endfunction

endpackage

// File: rtl/ret_pop_sequencer_if.sv
// Data-memory read port shared between the pop sequencer and the memory stage.
interface ret_pop_sequencer_if #(
    parameter int SP_W = 32
);
    logic            rd_req;
    logic [SP_W-1:0] rd_addr;
    logic            rd_valid;
    logic [15:0]     rd_data;

    modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
    modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/ret_pop_sequencer.sv
// Pops the return PC (and, with RTI_FLAGS_EN defined, the flags word) off the
// data-memory stack, then issues one redirect, one SP write and one flag write.
module ret_pop_sequencer
    import proc_pkg::*;
#(
    parameter int SP_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_i,
    input  logic                    is_rti_i,
    input  logic [SP_W-1:0]         sp_in_i,
    ret_pop_sequencer_if.master     mem,
    output logic                    busy_o,
    output logic [31:0]             pc_out_o,
    output logic                    pc_valid_o,
    output logic [FLAG_W-1:0]       flags_out_o,
    output logic                    flags_we_o,
    output logic [SP_W-1:0]         sp_out_o,
    output logic                    sp_we_o
);

    pop_state_e      state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [SP_W-1:0] sp_work_q, sp_work_d;
    logic [31:0]     pc_q, pc_d;
    logic [SP_W-1:0] sp_out_q, sp_out_d;
    logic            rd_req_q, rd_req_d;
    logic            busy_q, busy_d;
    logic            pc_valid_q, pc_valid_d;
    logic            sp_we_q, sp_we_d;
    logic            take_rti;

`ifdef RTI_FLAGS_EN
    logic              rti_q, rti_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              flags_we_q, flags_we_d;

    assign take_rti = is_rti_i;
`else
    logic unused_is_rti;

    assign unused_is_rti = is_rti_i;
    assign take_rti      = 1'b0;
`endif

    // sp_work holds the address of the word being popped, so it doubles as rd_addr.
    // NOTE: every always_comb output gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sp_work_d = sp_work_q;
        pc_d      = pc_q;
        sp_out_d  = sp_out_q;
`ifdef RTI_FLAGS_EN
        rti_d     = rti_q;
        flags_d   = flags_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    sp_work_d = sp_in_i + SP_W'(1);
                    cnt_d     = pop_words(take_rti);
`ifdef RTI_FLAGS_EN
                    rti_d     = is_rti_i;
`endif
                    state_d   = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (mem.rd_valid) begin
                    if (cnt_q == 2'd2) begin
                        pc_d[31:16] = mem.rd_data;
                    end else if (cnt_q == 2'd1) begin
                        pc_d[15:0] = mem.rd_data;
                    end
`ifdef RTI_FLAGS_EN
                    else if (cnt_q == POP_WORDS_RTI) begin
                        flags_d = mem.rd_data[FLAG_W-1:0];
                    end
`endif
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        sp_out_d = sp_work_q;
                        state_d  = DONE;
                    end else begin
                        sp_work_d = sp_work_q + SP_W'(1);
                        state_d   = REQ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they come straight out of flops.
        rd_req_d   = (state_d == REQ);
        busy_d     = (state_d != IDLE);
        pc_valid_d = (state_d == DONE);
        sp_we_d    = (state_d == DONE);
`ifdef RTI_FLAGS_EN
        flags_we_d = (state_d == DONE) && rti_q;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            sp_work_q  <= '0;
            pc_q       <= '0;
            sp_out_q   <= '0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            pc_valid_q <= 1'b0;
            sp_we_q    <= 1'b0;
`ifdef RTI_FLAGS_EN
            rti_q      <= 1'b0;
            flags_q    <= '0;
            flags_we_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sp_work_q  <= sp_work_d;
            pc_q       <= pc_d;
            sp_out_q   <= sp_out_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            pc_valid_q <= pc_valid_d;
            sp_we_q    <= sp_we_d;
`ifdef RTI_FLAGS_EN
            rti_q      <= rti_d;
            flags_q    <= flags_d;
            flags_we_q <= flags_we_d;
`endif
        end
    end

    assign mem.rd_req  = rd_req_q;
    assign mem.rd_addr = sp_work_q;
    assign busy_o      = busy_q;
    assign pc_out_o    = pc_q;
    assign pc_valid_o  = pc_valid_q;
    assign sp_out_o    = sp_out_q;
    assign sp_we_o     = sp_we_q;
`ifdef RTI_FLAGS_EN
    assign flags_out_o = flags_q;
    assign flags_we_o  = flags_we_q;
`else
    assign flags_out_o = '0;
    assign flags_we_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ret_pop_sequencer.sv
// Directed bench for ret_pop_sequencer: RTI/RET pops, wrap, stalls, ignored events, reset mid-op.
module tb_ret_pop_sequencer;

    localparam int SP_W = 32;
    localparam int WIN  = 14;

`ifdef RTI_FLAGS_EN
    localparam bit RTI_EN = 1'b1;
`else
    localparam bit RTI_EN = 1'b0;
`endif

    // Hand-computed expectations; without RTI support an RTI request is a 2-word pop.
    localparam int          EXP_RTI_DONE   = RTI_EN ? 7 : 5;
    localparam int          EXP_STALL_DONE = RTI_EN ? 9 : 7;
    localparam int          EXP_RTI_NPOP   = RTI_EN ? 3 : 2;
    localparam logic [31:0] EXP_RTI_PC     = RTI_EN ? 32'h0000_0123 : 32'h0005_0000;
    localparam logic [31:0] EXP_RTI_SP     = RTI_EN ? 32'h0000_0FF3 : 32'h0000_0FF2;
    localparam logic [2:0]  EXP_FLAGS      = RTI_EN ? 3'b101 : 3'b000;
    localparam int          EXP_RTI_FWE    = RTI_EN ? 1 : 0;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            is_rti;
    logic [SP_W-1:0] sp_in;
    logic            busy;
    logic [31:0]     pc_out;
    logic            pc_valid;
    logic [2:0]      flags_out;
    logic            flags_we;
    logic [SP_W-1:0] sp_out;
    logic            sp_we;

    ret_pop_sequencer_if #(.SP_W(SP_W)) mem_if ();

    ret_pop_sequencer #(.SP_W(SP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .is_rti_i   (is_rti),
        .sp_in_i    (sp_in),
        .mem        (mem_if.master),
        .busy_o     (busy),
        .pc_out_o   (pc_out),
        .pc_valid_o (pc_valid),
        .flags_out_o(flags_out),
        .flags_we_o (flags_we),
        .sp_out_o   (sp_out),
        .sp_we_o    (sp_we)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [logic [31:0]];
    int n_tests = 0;
    int n_fail  = 0;

    int          pcv_cnt, pcv_cyc, swe_cnt, swe_cyc, fwe_cnt;
    int          busy_cnt, busy_first, busy_last;
    logic [31:0] pc_seen, sp_seen;
    logic [2:0]  flags_seen;
    logic [31:0] addr_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rd_mem(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : 16'h0000;
    endfunction

    // Runs one request from cycle 0 (start accepted) for WIN cycles, acting as the memory.
    task automatic run_op(input bit rti, input logic [31:0] sp, input int stall_pop,
                          input int stall_extra, input int pulse_a, input int pulse_b,
                          input int rst_cyc);
        bit          pend = 1'b0;
        int          dly = 0;
        int          pop_idx = 0;
        logic [31:0] paddr = '0;
        pcv_cnt = 0; pcv_cyc = -1; swe_cnt = 0; swe_cyc = -1; fwe_cnt = 0;
        busy_cnt = 0; busy_first = -1; busy_last = -1;
        pc_seen = '0; sp_seen = '0; flags_seen = '0;
        addr_q.delete();
        for (int k = 0; k < WIN; k++) begin
            start  = (k == 0) || (k == pulse_a) || (k == pulse_b);
            is_rti = (k == 0) ? rti : !rti;
            sp_in  = (k == 0) ? sp : 32'hDEAD_BEEF;
            reset  = (k == rst_cyc) ? 1'b0 : 1'b1;
            mem_if.rd_valid = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    mem_if.rd_valid = 1'b1;
                    mem_if.rd_data  = rd_mem(paddr);
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end
            @(negedge clk);
            if (mem_if.rd_req) begin
                addr_q.push_back(mem_if.rd_addr);
                paddr = mem_if.rd_addr;
                pend  = 1'b1;
                dly   = (pop_idx == stall_pop) ? stall_extra : 0;
                pop_idx++;
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            if (pc_valid) begin
                pcv_cnt++;
                pcv_cyc    = k;
                pc_seen    = pc_out;
                flags_seen = flags_out;
            end
            if (sp_we) begin
                swe_cnt++;
                swe_cyc = k;
                sp_seen = sp_out;
            end
            if (flags_we) fwe_cnt++;
            if (k == rst_cyc) begin
                check("rst_mid.strobes", {mem_if.rd_req, busy, pc_valid, flags_we, sp_we}, 5'b0);
                check("rst_mid.rd_addr", mem_if.rd_addr, 0);
                check("rst_mid.pc_out", pc_out, 0);
                check("rst_mid.sp_out", sp_out, 0);
                check("rst_mid.flags_out", flags_out, 0);
            end
            @(posedge clk);
            #1;
        end
        start  = 1'b0;
        reset  = 1'b1;
        mem_if.rd_valid = 1'b0;
    endtask

    task automatic check_op(input string tag, input int exp_done, input logic [31:0] exp_pc,
                            input logic [31:0] exp_sp, input logic [2:0] exp_flags,
                            input int exp_fwe);
        check({tag, ".pc_valid_count"}, pcv_cnt, 1);
        check({tag, ".pc_valid_cycle"}, pcv_cyc, exp_done);
        check({tag, ".sp_we_count"}, swe_cnt, 1);
        check({tag, ".sp_we_cycle"}, swe_cyc, exp_done);
        check({tag, ".pc_out"}, pc_seen, exp_pc);
        check({tag, ".sp_out"}, sp_seen, exp_sp);
        check({tag, ".flags_we_count"}, fwe_cnt, exp_fwe);
        check({tag, ".flags_out"}, flags_seen, exp_flags);
        check({tag, ".busy_first"}, busy_first, 1);
        check({tag, ".busy_last"}, busy_last, exp_done);
        check({tag, ".busy_count"}, busy_cnt, exp_done);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; is_rti = 1'b0; sp_in = '0;
        mem_if.rd_valid = 1'b0; mem_if.rd_data = '0;
        mem[32'h0000_0FF1] = 16'h0005;
        mem[32'h0000_0FF2] = 16'h0000;
        mem[32'h0000_0FF3] = 16'h0123;
        mem[32'h0000_0FFE] = 16'h0001;
        mem[32'h0000_0FFF] = 16'h8000;
        mem[32'h0000_0000] = 16'h1234;
        mem[32'h0000_0001] = 16'h5678;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.strobes", {mem_if.rd_req, busy, pc_valid, flags_we, sp_we}, 5'b0);
        check("reset.rd_addr", mem_if.rd_addr, 0);
        check("reset.pc_out", pc_out, 0);
        check("reset.flags_out", flags_out, 0);
        check("reset.sp_out", sp_out, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(1'b1, 32'h0000_0FF0, -1, 0, -1, -1, -1);
        check_op("rti", EXP_RTI_DONE, EXP_RTI_PC, EXP_RTI_SP, EXP_FLAGS, EXP_RTI_FWE);
        check("rti.addr_count", addr_q.size(), EXP_RTI_NPOP);
        check("rti.addr0", addr_q[0], 32'h0000_0FF1);
        check("rti.addr1", addr_q[1], 32'h0000_0FF2);
`ifdef RTI_FLAGS_EN
        check("rti.addr2", addr_q[2], 32'h0000_0FF3);
`endif

        run_op(1'b0, 32'h0000_0FFD, -1, 0, -1, -1, -1);
        check_op("ret", 5, 32'h0001_8000, 32'h0000_0FFF, EXP_FLAGS, 0);
        check("ret.addr_count", addr_q.size(), 2);

        // Stray read response while idle must leave everything untouched.
        mem_if.rd_valid = 1'b1;
        mem_if.rd_data  = 16'hFFFF;
        @(negedge clk);
        @(posedge clk); #1;
        mem_if.rd_valid = 1'b0;
        @(negedge clk);
        check("stray.strobes", {mem_if.rd_req, busy, pc_valid, flags_we, sp_we}, 5'b0);
        check("stray.pc_out", pc_out, 32'h0001_8000);
        check("stray.sp_out", sp_out, 32'h0000_0FFF);
        @(posedge clk); #1;

        run_op(1'b0, 32'hFFFF_FFFF, -1, 0, -1, -1, -1);
        check_op("wrap", 5, 32'h1234_5678, 32'h0000_0001, EXP_FLAGS, 0);
        check("wrap.addr0", addr_q[0], 32'h0000_0000);
        check("wrap.addr1", addr_q[1], 32'h0000_0001);

        // Second pop answered with a 3-cycle read latency.
        run_op(1'b1, 32'h0000_0FF0, 1, 2, -1, -1, -1);
        check_op("stall", EXP_STALL_DONE, EXP_RTI_PC, EXP_RTI_SP, EXP_FLAGS, EXP_RTI_FWE);

        // Extra starts mid-sequence and in the DONE cycle are dropped.
        run_op(1'b1, 32'h0000_0FF0, -1, 0, 2, EXP_RTI_DONE, -1);
        check_op("ignored_start", EXP_RTI_DONE, EXP_RTI_PC, EXP_RTI_SP, EXP_FLAGS, EXP_RTI_FWE);

        // Reset in cycle 4 with the second read response still outstanding.
        run_op(1'b1, 32'h0000_0FF0, 1, 2, -1, -1, 4);
        check("rst_op.pc_valid_count", pcv_cnt, 0);
        check("rst_op.sp_we_count", swe_cnt, 0);
        check("rst_op.flags_we_count", fwe_cnt, 0);
        check("rst_op.busy_last", busy_last, 3);
        check("rst_op.pc_out_after", pc_out, 0);
        check("rst_op.sp_out_after", sp_out, 0);

        run_op(1'b0, 32'h0000_0FFD, -1, 0, -1, -1, -1);
        check_op("ret_after_rst", 5, 32'h0001_8000, 32'h0000_0FFF, 3'b000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
